// File: rtl/serial_add_sub.sv
// serial_add_sub: multi-cycle adder/subtractor. Each cycle it processes one
// DIGIT-bit digit, LSB first, through a ripple chain of full-adder slices and a
// carry flip-flop, under a Start/Busy/Done handshake.
// Optional feature macro: SERIAL_ADD_SUB_OVF_EN (builds the signed-overflow tap
// and the Ovf register; when it is undefined, Ovf is tied to 0).
module serial_add_sub #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIGIT = 1
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Start,
   input  logic             Sub,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic             Ovf
);

   localparam int unsigned N     = WIDTH / DIGIT;
   localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t             state;
   state_t             state_next;

   logic [WIDTH-1:0]   a_sr;
   logic [WIDTH-1:0]   b_sr;
   logic [WIDTH-1:0]   res_sr;
   logic [WIDTH-1:0]   res_next;
   logic               carry;
   logic [CNT_W-1:0]   cnt;

   logic [DIGIT-1:0]   sum;
   logic [DIGIT:0]     c;

   logic               load;
   logic               last;

   // Operands are accepted only when no operation is in flight.
   assign load = Start && ((state == ST_IDLE) || (state == ST_DONE));
   assign last = (state == ST_RUN) && (cnt == CNT_W'(N - 1));

   // Ripple chain of DIGIT full-adder slices fed by the carry flip-flop.
   always_comb begin
      sum  = '0;
      c    = '0;
      c[0] = carry;
      for (int unsigned i = 0; i < DIGIT; i++) begin
         sum[i]   = a_sr[i] ^ b_sr[i] ^ c[i];
         c[i + 1] = (a_sr[i] & b_sr[i]) | (b_sr[i] & c[i]) | (a_sr[i] & c[i]);
      end
   end

   // New sum digit enters the result register from the MSB side.
   always_comb begin
      res_next = (res_sr >> DIGIT) | (WIDTH'(sum) << (WIDTH - DIGIT));
   end

   // State register.
   always_ff @(posedge Clk) begin
      if (Rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   // Next-state logic and Moore handshake outputs.
   always_comb begin
      state_next = state;
      Busy       = 1'b0;
      Done       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (Start) state_next = ST_RUN;
         end
         ST_RUN: begin
            Busy = 1'b1;
            if (last) state_next = ST_DONE;
         end
         ST_DONE: begin
            Done = 1'b1;
            if (Start) state_next = ST_RUN;
            else       state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Operand shift registers, carry, digit counter and result registers.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         S      <= '0;
         Cout   <= 1'b0;
      end else if (load) begin
         a_sr   <= A;
         b_sr   <= Sub ? ~B : B;
         res_sr <= '0;
         carry  <= Sub;
         cnt    <= '0;
      end else if (state == ST_RUN) begin
         a_sr   <= a_sr >> DIGIT;
         b_sr   <= b_sr >> DIGIT;
         res_sr <= res_next;
         carry  <= c[DIGIT];
         cnt    <= cnt + CNT_W'(1);
         if (last) begin
            S    <= res_next;
            Cout <= c[DIGIT];
         end
      end
   end

`ifdef SERIAL_ADD_SUB_OVF_EN
   // Signed overflow: carry into the MSB differs from carry out of it.
   always_ff @(posedge Clk) begin
      if (Rst)       Ovf <= 1'b0;
      else if (last) Ovf <= c[DIGIT - 1] ^ c[DIGIT];
   end
`else
   assign Ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub: a WIDTH=8/DIGIT=1 instance and a
// WIDTH=8/DIGIT=4 instance, checked against an integer-arithmetic reference.
module tb_serial_add_sub;

`ifdef SERIAL_ADD_SUB_OVF_EN
   localparam bit OVF_ON = 1'b1;
`else
   localparam bit OVF_ON = 1'b0;
`endif

   logic       Clk = 1'b0;
   logic       Rst;

   logic       start8, sub8, busy8, done8, cout8, ovf8;
   logic [7:0] a8, b8, s8;
   logic       start4, sub4, busy4, done4, cout4, ovf4;
   logic [7:0] a4, b4, s4;

   bit         sel;
   logic       busy_m, done_m, cout_m, ovf_m;
   logic [7:0] s_m;

   int         n_checks = 0;
   int         n_fail   = 0;

   always #5 Clk = ~Clk;

   serial_add_sub #(.WIDTH(8), .DIGIT(1)) dut8 (
      .Clk(Clk), .Rst(Rst), .Start(start8), .Sub(sub8), .A(a8), .B(b8),
      .Busy(busy8), .Done(done8), .S(s8), .Cout(cout8), .Ovf(ovf8)
   );

   serial_add_sub #(.WIDTH(8), .DIGIT(4)) dut4 (
      .Clk(Clk), .Rst(Rst), .Start(start4), .Sub(sub4), .A(a4), .B(b4),
      .Busy(busy4), .Done(done4), .S(s4), .Cout(cout4), .Ovf(ovf4)
   );

   assign busy_m = sel ? busy4 : busy8;
   assign done_m = sel ? done4 : done8;
   assign s_m    = sel ? s4    : s8;
   assign cout_m = sel ? cout4 : cout8;
   assign ovf_m  = sel ? ovf4  : ovf8;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       sub;
      logic [7:0] s;
      logic       cout;
      logic       ovf;
   } vec_t;

   vec_t vecs[8];

   // Reference: plain signed/unsigned integer arithmetic.
   function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic sub);
      int ua, ub, ur, sa, sb, r;
      logic c, o;
      ua = a;
      ub = b;
      sa = $signed(a);
      sb = $signed(b);
      if (sub) begin
         ur = ua - ub;
         r  = sa - sb;
         c  = (ua >= ub);
      end else begin
         ur = ua + ub;
         r  = sa + sb;
         c  = (ur > 255);
      end
      o = (r > 127) || (r < -128);
      return {ur[7:0], c, o & OVF_ON};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge Clk);
      #1;
   endtask

   task automatic drive(input bit which, input logic st, input logic [7:0] a,
                        input logic [7:0] b, input logic sub);
      if (which) begin
         start4 = st; a4 = a; b4 = b; sub4 = sub;
      end else begin
         start8 = st; a8 = a; b8 = b; sub8 = sub;
      end
   endtask

   // Waits (bounded) for Done; counts ticks taken and Busy cycles seen.
   task automatic wait_done(output int lat, output int busy_n);
      lat    = 0;
      busy_n = 0;
      while (!done_m && lat < 40) begin
         if (busy_m) busy_n++;
         tick();
         lat++;
      end
      check("done_timeout", 32'(done_m), 32'd1);
   endtask

   task automatic run_op(input bit which, input logic [7:0] a, input logic [7:0] b,
                         input logic sub, output int lat, output int busy_n);
      sel = which;
      drive(which, 1'b1, a, b, sub);
      tick();
      drive(which, 1'b0, a, b, sub);
      wait_done(lat, busy_n);
   endtask

   initial begin
      int lat, busy_n, pulses;
      logic [9:0] exp;
      logic [7:0] ra, rb, cap_s;
      logic       rs;

      vecs[0] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
      vecs[2] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0};
      vecs[3] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
      vecs[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
      vecs[5] = '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0};
      vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
      vecs[7] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0};

      sel = 1'b0;
      Rst = 1'b1;
      drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
      tick();
      tick();
      check("rst_busy", 32'(busy8), 32'd0);
      check("rst_done", 32'(done8), 32'd0);
      check("rst_s",    32'(s8),    32'd0);
      check("rst_cout", 32'(cout8), 32'd0);
      check("rst_ovf",  32'(ovf8),  32'd0);
      Rst = 1'b0;
      tick();

      // Directed vector table on the DIGIT=1 instance.
      for (int i = 0; i < 8; i++) begin
         run_op(1'b0, vecs[i].a, vecs[i].b, vecs[i].sub, lat, busy_n);
         check("vec_s",     32'(s8),    32'(vecs[i].s));
         check("vec_cout",  32'(cout8), 32'(vecs[i].cout));
         check("vec_ovf",   32'(ovf8),  32'(vecs[i].ovf & OVF_ON));
         check("vec_lat",   32'(lat + 1), 32'd9);
         check("vec_busyn", 32'(busy_n), 32'd8);
         check("vec_busy_at_done", 32'(busy8), 32'd0);
         tick();
         check("done_one_cycle", 32'(done8), 32'd0);
         check("s_held", 32'(s8), 32'(vecs[i].s));
      end

      // Start pulsed during RUN is ignored.
      sel = 1'b0;
      drive(1'b0, 1'b1, 8'h12, 8'h34, 1'b0);
      tick();
      drive(1'b0, 1'b0, 8'h12, 8'h34, 1'b0);
      tick();
      tick();
      drive(1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1);
      tick();
      drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      pulses = 0;
      cap_s  = 8'h00;
      for (int k = 0; k < 25; k++) begin
         if (done8) begin
            pulses++;
            cap_s = s8;
         end
         tick();
      end
      check("ign_pulses", 32'(pulses), 32'd1);
      check("ign_s", 32'(cap_s), 32'h46);

      // Back-to-back: Start held in DONE goes straight back to RUN.
      run_op(1'b0, 8'h10, 8'h20, 1'b0, lat, busy_n);
      check("b2b_s1", 32'(s8), 32'h30);
      drive(1'b0, 1'b1, 8'h50, 8'h30, 1'b1);
      tick();
      drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      check("b2b_busy", 32'(busy8), 32'd1);
      check("b2b_done", 32'(done8), 32'd0);
      check("b2b_s_held", 32'(s8), 32'h30);
      wait_done(lat, busy_n);
      check("b2b_lat", 32'(lat), 32'd8);
      check("b2b_s2", 32'(s8), 32'h20);
      check("b2b_cout", 32'(cout8), 32'd1);
      check("b2b_ovf", 32'(ovf8), 32'd0);
      tick();

      // Reset in the middle of RUN aborts without a Done.
      drive(1'b0, 1'b1, 8'h7F, 8'h01, 1'b0);
      tick();
      drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      tick();
      tick();
      tick();
      Rst = 1'b1;
      tick();
      Rst = 1'b0;
      check("mid_rst_busy", 32'(busy8), 32'd0);
      check("mid_rst_done", 32'(done8), 32'd0);
      check("mid_rst_s",    32'(s8),    32'd0);
      check("mid_rst_cout", 32'(cout8), 32'd0);
      check("mid_rst_ovf",  32'(ovf8),  32'd0);
      pulses = 0;
      for (int k = 0; k < 20; k++) begin
         if (done8 || busy8) pulses++;
         tick();
      end
      check("mid_rst_quiet", 32'(pulses), 32'd0);

      // DIGIT=4 instance.
      run_op(1'b1, 8'h3C, 8'h4B, 1'b0, lat, busy_n);
      check("d4_s",    32'(s4),    32'h87);
      check("d4_cout", 32'(cout4), 32'd0);
      check("d4_ovf",  32'(ovf4),  32'(OVF_ON));
      check("d4_lat",  32'(lat + 1), 32'd3);
      check("d4_busyn", 32'(busy_n), 32'd2);
      tick();

      // Randomized operations on both instances against the reference.
      for (int k = 0; k < 40; k++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         rs = 1'($urandom_range(0, 1));
         exp = model(ra, rb, rs);
         run_op(k >= 30, ra, rb, rs, lat, busy_n);
         check("rnd_s",    32'(s_m),    32'(exp[9:2]));
         check("rnd_cout", 32'(cout_m), 32'(exp[1]));
         check("rnd_ovf",  32'(ovf_m),  32'(exp[0]));
         check("rnd_lat",  32'(lat), (k >= 30) ? 32'd2 : 32'd8);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_add_sub.md
# serial_add_sub

Parametrised multi-cycle adder/subtractor built around a chain of `DIGIT` full-adder slices and a carry flip-flop. It processes a `WIDTH`-bit operand pair `DIGIT` bits per clock, LSB first, under a Start/Busy/Done handshake. It is the area-reduced, sequential successor to the single-bit combinational full adder, and it serves datapath labs that trade latency for logic.

## Interface
Parameters:
- `WIDTH`, default 8: operand and result width. Must be at least 2.
- `DIGIT`, default 1: bits processed per cycle. Must divide `WIDTH`. `N = WIDTH/DIGIT` is the number of compute cycles.

Ports (`name  direction  width  meaning`):
- `Clk  input  1  clock`; everything is sampled on the rising edge.
- `Rst  input  1  reset`, synchronous and active-high.
- `Start  input  1  request`; sampled only in IDLE or DONE.
- `Sub  input  1`: 0 computes A+B, 1 computes A−B. Sampled with Start.
- `A  input  WIDTH  operand A`; sampled with Start.
- `B  input  WIDTH  operand B`; sampled with Start.
- `Busy  output  1`: high while in RUN.
- `Done  output  1`: one-cycle pulse when a result is loaded.
- `S  output  WIDTH`: result, held until the next completion.
- `Cout  output  1`: carry out of the MSB. For subtraction, 1 means no borrow.
- `Ovf  output  1`: two's-complement signed overflow.

## Operation
The FSM has three states: IDLE, RUN, DONE. Reset state is IDLE.
- **IDLE, Start=1:** load the A shift register with A. Load the B shift register with B, or ~B when Sub=1. Set carry FF to Sub. Clear the digit counter. Go to RUN.
- **RUN:** each cycle, add the low `DIGIT` bits of both shift registers plus carry FF through the slice chain (S=a^b^c, C=ab|bc|ac). Shift the sum digit into the result register from the MSB side. Shift the operand registers right by `DIGIT`. Update carry FF and increment the counter.
- **RUN, last digit (counter = N−1):** copy the completed result register to `S`. Load `Cout` with the final carry. Load `Ovf` with carry-into-MSB XOR carry-out-of-MSB. Go to DONE.
- **DONE:** `Done`=1.
  - Start=1: behave exactly as IDLE+Start, going to RUN. This allows back-to-back operations.
  - Otherwise: go to IDLE.
- **Start during RUN:** ignored. Operands are not resampled and the operation in flight is unaffected.
- **Arithmetic:** results are modulo 2^WIDTH. Overflow is never saturated.
- **Outputs:** `S`, `Cout` and `Ovf` change only on entry to DONE, or on reset.

## Timing
- **Reset:** Rst=1 at an edge forces IDLE and clears `Busy`, `Done`, `S`, `Cout`, `Ovf`, the shift registers, carry FF and counter to 0. Rst has priority over Start.
- **Reset mid-RUN:** aborts the operation. No Done is produced and no partial result appears on `S`.
- **Latency:** Start sampled at edge t gives RUN on edges t+1 … t+N.
  - `Busy`=1 in the cycles following edges t through t+N−1.
  - Results and `Done`=1 become visible after edge t+N. `Done` lasts exactly one cycle.
  - Start-to-Done is N+1 cycles if Start is not held.
- **Throughput:** one operation per N+1 cycles when Start is asserted in DONE.
- **Outputs:** `Busy` and `Done` are Moore outputs and are never high together.

## Configuration
- **`SERIAL_ADD_SUB_OVF_EN` defined:** the carry-into-MSB tap and `Ovf` register are built, and `Ovf` behaves as specified above.
- **Macro undefined:** the tap and register are omitted and `Ovf` is tied to constant 0. All other behaviour and timing are identical.

## Test plan
All scenarios use WIDTH=8, DIGIT=1 with the macro defined, except the DIGIT=4 case.
- **Signed overflow on add:** Start, Sub=0, A=0x7F, B=0x01 -> Done after 9 edges, S=0x80, Cout=0, Ovf=1. Busy high for exactly 8 cycles.
- **Unsigned wrap:** Sub=0, A=0xFF, B=0x01 -> S=0x00, Cout=1, Ovf=0.
- **Subtract with borrow:** Sub=1, A=0x05, B=0x07 -> S=0xFE, Cout=0 (borrow), Ovf=0. Then A=0x80, B=0x01 -> S=0x7F, Cout=1, Ovf=1.
- **Start ignored during RUN:** pulse Start with new operands at RUN cycle 3 -> first result unchanged and exactly one Done. Then hold Start in DONE -> second operation begins with no IDLE cycle.
- **Reset mid-operation:** assert Rst at RUN cycle 4 -> next cycle all outputs 0, state IDLE, no Done for 20 cycles afterwards.
- **DIGIT=4:** A=0x3C, B=0x4B, Sub=0 -> S=0x87, Ovf=1, Cout=0, Done after 3 edges. Rebuild without the macro -> Ovf stays 0 throughout.
